cmd_issue_arbiter: RTL and testbench
====================================

Name: cmd_issue_arbiter

Overview:
- Front-end scheduler that fills the command issue FIFO consumed by the command scheduler.
- Arbitrates between a host read-request queue, a host write-request queue and an internal refresh timer.
- Tracks the open row of every bank and expands each host request into the required PRECHARGE/ACTIVE/READ|WRITE sequence (open-page policy). Refresh is expanded into PRECHARGE of each open bank, then REFRESH.

Parameters:
- NUM_BANKS, 8, number of banks tracked (power of 2)
- BA_BITS, 3, bank address width (log2 NUM_BANKS)
- ROW_BITS, 16, row address width
- COL_BITS, 10, column address width
- TREFI_CYC, 3900, clk cycles between refresh requests
- WR_STARVE_MAX, 15, consecutive read grants after which a pending write wins

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- init_done  in  1  level; DRAM initialisation complete
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request accepted (pop)
- rd_bank / rd_row / rd_col  in  BA_BITS / ROW_BITS / COL_BITS  read request address
- wr_valid  in  1  write request valid
- wr_ready  out  1  write request accepted (pop)
- wr_bank / wr_row / wr_col  in  BA_BITS / ROW_BITS / COL_BITS  write request address
- issue_full  in  1  issue FIFO full
- issue_push  out  1  issue FIFO write enable
- issue_cmd  out  3  command_t: ACTIVE, PRECHARGE, READ, WRITE, REFRESH
- issue_bank / issue_row / issue_col  out  BA_BITS / ROW_BITS / COL_BITS  command address
- ref_overflow  out  1  one-cycle pulse when the refresh interval expires while a refresh is still pending

Behaviour:
- Reset values: all outputs 0, state S_INIT, open_valid[] = 0, refresh counter = TREFI_CYC, ref_pending = 0, starve counter = 0.
- S_INIT: go to S_IDLE on the first cycle init_done = 1. The refresh counter is held at TREFI_CYC until then.
- Refresh timer (active after init):
  - Decrements every cycle.
  - At 0: reload TREFI_CYC and set ref_pending.
  - If ref_pending is already 1 at that moment, also pulse ref_overflow.
  - ref_pending clears when REFRESH is pushed.
- Arbitration, evaluated only in S_IDLE, priority order:
  - ref_pending
  - write, if wr_valid and (starve counter = WR_STARVE_MAX or !rd_valid)
  - read
- Request grant:
  - The selected rd_ready or wr_ready pulses for exactly one cycle, in the S_IDLE cycle of selection.
  - Address and type are latched in that cycle. Ready is never asserted outside S_IDLE.
  - Starve counter: +1 on a read grant while wr_valid = 1 (saturating), cleared on a write grant.
- Next state from S_IDLE after a grant:
  - Open bank, same row (hit) -> S_RW.
  - Open bank, different row (conflict) -> S_PRE.
  - Closed bank -> S_ACT.
- Command push rules:
  - Every command state pushes exactly one command, asserting issue_push for one cycle, and only when issue_full = 0.
  - While issue_full = 1 the state holds and outputs stay stable with issue_push = 0.
- S_PRE: push PRECHARGE (bank); clear open_valid[bank]; -> S_ACT.
- S_ACT: push ACTIVE (bank, row); set open_valid[bank], open_row[bank] = row; -> S_RW.
- S_RW: push READ or WRITE (bank, col); -> S_IDLE.
- Latency with issue_full = 0 (grant at cycle N):
  - Hit: push at N+1.
  - Closed bank: N+1, N+2.
  - Conflict: N+1, N+2, N+3.
  - Next grant possible one cycle after the last push.
- Refresh selection -> S_REF_PRE:
  - Each cycle, push PRECHARGE for the lowest-index bank with open_valid = 1 and clear that bit.
  - When no bank is open -> S_REF.
- S_REF: push REFRESH (bank/row/col fields = 0); clear ref_pending; -> S_IDLE.
- An in-flight request sequence is never pre-empted by refresh; ref_pending is served at the next S_IDLE.
- rd and wr simultaneously valid with starve counter < WR_STARVE_MAX -> read wins.
- init_done deasserting after S_INIT is ignored.
- Asynchronous reset mid-sequence: returns everything to reset values immediately; any partially issued sequence is abandoned and all banks are treated as closed.

Decomposition:
- Shared package command_definition_pkg:
  - command_t encoding, shared with the command scheduler.
  - arbiter state enum (S_INIT, S_IDLE, S_PRE, S_ACT, S_RW, S_REF_PRE, S_REF).
- Sub-module refresh_timer:
  - Inputs: clk, rst_n, enable, ref_done.
  - Outputs: ref_pending, ref_overflow.
  - Parameter: TREFI_CYC.
- Open-row table and priority encoder stay inline.

Test Plan:
- Read bank 2, row 0x10, col 0x8 after init, banks closed -> pushes ACTIVE(2,0x10) at N+1, READ(2,col 0x8) at N+2; rd_ready pulses once at N.
- Second read bank 2, row 0x10 -> single READ at N+1; then read bank 2, row 0x20 -> PRECHARGE(2), ACTIVE(2,0x20), READ on consecutive cycles.
- issue_full held high 5 cycles during S_ACT -> no push, outputs stable; ACTIVE pushed on the first cycle full drops.
- rd_valid and wr_valid both held high with row hits -> 15 READs granted, then 1 WRITE, then reads resume.
- TREFI_CYC = 20, banks 1 and 5 open -> after 20 cycles PRECHARGE(1), PRECHARGE(5), REFRESH; ref_pending clears; the next request to bank 1 issues ACTIVE.
- Refresh blocked by issue_full for more than TREFI_CYC cycles -> ref_overflow pulses once; rst_n asserted mid-conflict sequence -> all outputs 0 and the next request issues ACTIVE without PRECHARGE.

Source files
------------

// File: rtl/command_definition_pkg.sv
// Command encoding shared with the command scheduler, plus the issue arbiter state set.
// CMD_NOP is what the issue bus carries when no command is staged.
package command_definition_pkg;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_ACTIVE    = 3'd1,
        CMD_PRECHARGE = 3'd2,
        CMD_READ      = 3'd3,
        CMD_WRITE     = 3'd4,
        CMD_REFRESH   = 3'd5
    } command_t;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_PRE,
        S_ACT,
        S_RW,
        S_REF_PRE,
        S_REF
    } arb_state_t;

    function automatic command_t rw_cmd(input logic is_wr);
        if (is_wr) return CMD_WRITE;
        return CMD_READ;
    endfunction

endpackage

// File: rtl/cmd_issue_arbiter_if.sv
// Host read/write request queues and issue FIFO write port of the command issue arbiter.
// master = request/FIFO side, slave = arbiter; valid/ready pop on requests, full-gated push on issue.
interface cmd_issue_arbiter_if
    import command_definition_pkg::*;
#(
    parameter int BA_BITS  = 3,
    parameter int ROW_BITS = 16,
    parameter int COL_BITS = 10
);
    logic                rd_valid;
    logic                rd_ready;
    logic [BA_BITS-1:0]  rd_bank;
    logic [ROW_BITS-1:0] rd_row;
    logic [COL_BITS-1:0] rd_col;

    logic                wr_valid;
    logic                wr_ready;
    logic [BA_BITS-1:0]  wr_bank;
    logic [ROW_BITS-1:0] wr_row;
    logic [COL_BITS-1:0] wr_col;

    logic                issue_full;
    logic                issue_push;
    command_t            issue_cmd;
    logic [BA_BITS-1:0]  issue_bank;
    logic [ROW_BITS-1:0] issue_row;
    logic [COL_BITS-1:0] issue_col;

    modport master (
        output rd_valid, rd_bank, rd_row, rd_col,
        output wr_valid, wr_bank, wr_row, wr_col,
        output issue_full,
        input  rd_ready, wr_ready,
        input  issue_push, issue_cmd, issue_bank, issue_row, issue_col
    );

    modport slave (
        input  rd_valid, rd_bank, rd_row, rd_col,
        input  wr_valid, wr_bank, wr_row, wr_col,
        input  issue_full,
        output rd_ready, wr_ready,
        output issue_push, issue_cmd, issue_bank, issue_row, issue_col
    );
endinterface

// File: rtl/refresh_timer.sv
// Refresh interval timer: counts down from TREFI_CYC once enabled, raises ref_pending on expiry.
// Pending holds until ref_done; an expiry while still pending gives a one-cycle ref_overflow.
module refresh_timer #(
    parameter int TREFI_CYC = 3900
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic ref_done,
    output logic ref_pending,
    output logic ref_overflow
);
    localparam int CNT_W = $clog2(TREFI_CYC + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= CNT_W'(TREFI_CYC);
            ref_pending  <= 1'b0;
            ref_overflow <= 1'b0;
        end else begin
            ref_overflow <= 1'b0;
            if (ref_done)
                ref_pending <= 1'b0;
            if (enable) begin
                if (cnt == '0) begin
                    // a fresh expiry re-arms pending even if REFRESH leaves this same cycle
                    cnt          <= CNT_W'(TREFI_CYC);
                    ref_pending  <= 1'b1;
                    ref_overflow <= ref_pending;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/cmd_issue_arbiter.sv
// Picks refresh > starved write > read, expands each into PRE/ACT/RD|WR (open page) on the issue FIFO.
// Grant pops a request in S_IDLE; one command per state, stalled while issue_full with outputs held.
module cmd_issue_arbiter
    import command_definition_pkg::*;
#(
    parameter int NUM_BANKS     = 8,
    parameter int BA_BITS       = 3,
    parameter int ROW_BITS      = 16,
    parameter int COL_BITS      = 10,
    parameter int TREFI_CYC     = 3900,
    parameter int WR_STARVE_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init_done,
    cmd_issue_arbiter_if.slave bus,
    output logic               ref_overflow
);
    localparam int SC_W = $clog2(WR_STARVE_MAX + 1);

    typedef struct packed {
        command_t            cmd;
        logic [BA_BITS-1:0]  bank;
        logic [ROW_BITS-1:0] row;
        logic [COL_BITS-1:0] col;
    } issue_t;

    arb_state_t          state;
    issue_t              cur;
    logic [NUM_BANKS-1:0] open_valid;
    logic [ROW_BITS-1:0] open_row [NUM_BANKS];
    logic [SC_W-1:0]     starve_cnt;
    logic                req_wr;
    logic [BA_BITS-1:0]  req_bank;
    logic [ROW_BITS-1:0] req_row;
    logic [COL_BITS-1:0] req_col;

    logic                ref_pending;
    logic                ref_done;
    logic                timer_en;
    logic                sel_wr;
    logic                sel_rd;
    logic                in_idle;
    logic                push;
    logic                row_open;
    logic                row_hit;
    logic [BA_BITS-1:0]  g_bank;
    logic [ROW_BITS-1:0] g_row;
    logic [COL_BITS-1:0] g_col;
    logic [NUM_BANKS-1:0] ref_left;

    function automatic issue_t mk(input command_t cc, input logic [BA_BITS-1:0] bb,
                                  input logic [ROW_BITS-1:0] rr, input logic [COL_BITS-1:0] ll);
        return '{cmd: cc, bank: bb, row: rr, col: ll};
    endfunction

    function automatic logic [BA_BITS-1:0] lowest_open(input logic [NUM_BANKS-1:0] v);
        logic [BA_BITS-1:0] idx;
        idx = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--)
            if (v[i]) idx = BA_BITS'(i);
        return idx;
    endfunction

    assign in_idle  = (state == S_IDLE);
    assign sel_wr   = !ref_pending && bus.wr_valid &&
                      ((starve_cnt == SC_W'(WR_STARVE_MAX)) || !bus.rd_valid);
    assign sel_rd   = !ref_pending && !sel_wr && bus.rd_valid;
    assign g_bank   = sel_wr ? bus.wr_bank : bus.rd_bank;
    assign g_row    = sel_wr ? bus.wr_row  : bus.rd_row;
    assign g_col    = sel_wr ? bus.wr_col  : bus.rd_col;
    assign row_open = open_valid[g_bank];
    assign row_hit  = row_open && (open_row[g_bank] == g_row);

    // cur holds the staged command; CMD_NOP means nothing to push this cycle
    assign push     = (cur.cmd != CMD_NOP) && !bus.issue_full;
    assign ref_left = open_valid & ~(NUM_BANKS'(1) << cur.bank);
    assign ref_done = push && (state == S_REF);
    assign timer_en = (state != S_INIT);

    assign bus.rd_ready   = in_idle && sel_rd;
    assign bus.wr_ready   = in_idle && sel_wr;
    assign bus.issue_push = push;
    assign bus.issue_cmd  = cur.cmd;
    assign bus.issue_bank = cur.bank;
    assign bus.issue_row  = cur.row;
    assign bus.issue_col  = cur.col;

    refresh_timer #(.TREFI_CYC(TREFI_CYC)) u_refresh_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (timer_en),
        .ref_done    (ref_done),
        .ref_pending (ref_pending),
        .ref_overflow(ref_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INIT;
            cur        <= '0;
            open_valid <= '0;
            starve_cnt <= '0;
            req_wr     <= 1'b0;
            req_bank   <= '0;
            req_row    <= '0;
            req_col    <= '0;
            for (int i = 0; i < NUM_BANKS; i++)
                open_row[i] <= '0;
        end else begin
            case (state)
                S_INIT: if (init_done) state <= S_IDLE;
                S_IDLE: begin
                    if (ref_pending) begin
                        if (|open_valid) begin
                            state <= S_REF_PRE;
                            cur   <= mk(CMD_PRECHARGE, lowest_open(open_valid), '0, '0);
                        end else begin
                            state <= S_REF;
                            cur   <= mk(CMD_REFRESH, '0, '0, '0);
                        end
                    end else if (sel_wr || sel_rd) begin
                        req_wr   <= sel_wr;
                        req_bank <= g_bank;
                        req_row  <= g_row;
                        req_col  <= g_col;
                        if (sel_wr)
                            starve_cnt <= '0;
                        else if (bus.wr_valid && (starve_cnt != SC_W'(WR_STARVE_MAX)))
                            starve_cnt <= starve_cnt + 1'b1;
                        if (row_hit) begin
                            state <= S_RW;
                            cur   <= mk(rw_cmd(sel_wr), g_bank, '0, g_col);
                        end else if (row_open) begin
                            state <= S_PRE;
                            cur   <= mk(CMD_PRECHARGE, g_bank, '0, '0);
                        end else begin
                            state <= S_ACT;
                            cur   <= mk(CMD_ACTIVE, g_bank, g_row, '0);
                        end
                    end
                end
                S_PRE: if (push) begin
                    open_valid[req_bank] <= 1'b0;
                    state <= S_ACT;
                    cur   <= mk(CMD_ACTIVE, req_bank, req_row, '0);
                end
                S_ACT: if (push) begin
                    open_valid[req_bank] <= 1'b1;
                    open_row[req_bank]   <= req_row;
                    state <= S_RW;
                    cur   <= mk(rw_cmd(req_wr), req_bank, '0, req_col);
                end
                S_RW: if (push) begin
                    state <= S_IDLE;
                    cur   <= '0;
                end
                S_REF_PRE: if (push) begin
                    // look ahead so the next open bank is precharged on the very next cycle
                    open_valid <= ref_left;
                    if (|ref_left) begin
                        cur <= mk(CMD_PRECHARGE, lowest_open(ref_left), '0, '0);
                    end else begin
                        state <= S_REF;
                        cur   <= mk(CMD_REFRESH, '0, '0, '0);
                    end
                end
                S_REF: if (push) begin
                    state <= S_IDLE;
                    cur   <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    cur   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_issue_arbiter.sv
// Directed bench for cmd_issue_arbiter: page hit/miss/conflict, backpressure, write starvation,
// refresh expansion, refresh overflow and mid-sequence reset.
module tb_cmd_issue_arbiter;
    import command_definition_pkg::*;

    localparam int TREFI = 60;

    logic clk;
    logic rst_n;
    logic init_done;
    logic ref_overflow;

    int vectors;
    int miscompares;
    int nrd, nwr, nread, npush, novf, ovf_cyc;

    cmd_issue_arbiter_if #(.BA_BITS(3), .ROW_BITS(16), .COL_BITS(10)) bus ();

    cmd_issue_arbiter #(
        .NUM_BANKS(8), .BA_BITS(3), .ROW_BITS(16), .COL_BITS(10),
        .TREFI_CYC(TREFI), .WR_STARVE_MAX(15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_done   (init_done),
        .bus         (bus),
        .ref_overflow(ref_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_issue(input string tag, input logic p, input command_t c,
                             input int b, input int r, input int cl);
        logic [32:0] obs;
        logic [32:0] exp;
        obs = {bus.issue_push, bus.issue_cmd, bus.issue_bank, bus.issue_row, bus.issue_col};
        exp = {p, c, 3'(b), 16'(r), 10'(cl)};
        chk(tag, 64'(obs), 64'(exp));
    endtask

    task automatic rd_req(input logic v, input int b, input int r, input int c);
        bus.rd_valid = v;
        bus.rd_bank  = 3'(b);
        bus.rd_row   = 16'(r);
        bus.rd_col   = 10'(c);
    endtask

    task automatic wr_req(input logic v, input int b, input int r, input int c);
        bus.wr_valid = v;
        bus.wr_bank  = 3'(b);
        bus.wr_row   = 16'(r);
        bus.wr_col   = 10'(c);
    endtask

    // leaves the caller at the start (negedge) of the first S_IDLE cycle, timer at TREFI
    task automatic do_reset();
        rst_n = 1'b0;
        init_done = 1'b0;
        bus.issue_full = 1'b0;
        rd_req(0, 0, 0, 0);
        wr_req(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        init_done = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;

        // reset state with requests already waiting
        rst_n = 1'b0;
        init_done = 1'b0;
        bus.issue_full = 1'b0;
        rd_req(1, 1, 1, 1);
        wr_req(1, 2, 2, 2);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_issue("R issue bus in reset", 0, CMD_NOP, 0, 0, 0);
        chk("R rd_ready in reset", bus.rd_ready, 0);
        chk("R wr_ready in reset", bus.wr_ready, 0);
        chk("R ref_overflow in reset", ref_overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("R no grant before init_done", bus.rd_ready, 0);

        // closed bank -> ACT+READ, hit -> READ, conflict -> PRE+ACT+READ
        do_reset();
        init_done = 1'b0;
        rd_req(1, 2, 'h10, 'h8);
        #1;
        chk("A0 rd_ready grant", bus.rd_ready, 1);
        chk_issue("A0 no push in grant cycle", 0, CMD_NOP, 0, 0, 0);
        @(negedge clk); rd_req(0, 0, 0, 0); #1;
        chk("A1 rd_ready single pulse", bus.rd_ready, 0);
        chk_issue("A1 ACTIVE", 1, CMD_ACTIVE, 2, 'h10, 0);
        @(negedge clk); #1;
        chk_issue("A2 READ", 1, CMD_READ, 2, 0, 'h8);
        @(negedge clk); rd_req(1, 2, 'h10, 'h9); #1;
        chk("A3 hit grant", bus.rd_ready, 1);
        chk_issue("A3 idle", 0, CMD_NOP, 0, 0, 0);
        @(negedge clk); rd_req(1, 2, 'h20, 'h3); #1;
        chk_issue("A4 hit READ", 1, CMD_READ, 2, 0, 'h9);
        chk("A4 no ready outside idle", bus.rd_ready, 0);
        @(negedge clk); #1;
        chk("A5 conflict grant", bus.rd_ready, 1);
        @(negedge clk); rd_req(0, 0, 0, 0); #1;
        chk_issue("A6 PRECHARGE", 1, CMD_PRECHARGE, 2, 0, 0);
        @(negedge clk); #1;
        chk_issue("A7 ACTIVE", 1, CMD_ACTIVE, 2, 'h20, 0);
        @(negedge clk); #1;
        chk_issue("A8 READ", 1, CMD_READ, 2, 0, 'h3);

        // backpressure held for five cycles while ACTIVE is staged
        @(negedge clk); rd_req(1, 4, 'h33, 1); #1;
        chk("A9 grant", bus.rd_ready, 1);
        @(negedge clk); rd_req(0, 0, 0, 0); bus.issue_full = 1'b1; #1;
        chk_issue("A10 full holds ACTIVE", 0, CMD_ACTIVE, 4, 'h33, 0);
        for (int i = 11; i <= 14; i++) begin
            @(negedge clk); #1;
            chk_issue("A full holds ACTIVE", 0, CMD_ACTIVE, 4, 'h33, 0);
        end
        @(negedge clk); bus.issue_full = 1'b0; #1;
        chk_issue("A15 ACTIVE after full drops", 1, CMD_ACTIVE, 4, 'h33, 0);
        @(negedge clk); #1;
        chk_issue("A16 READ", 1, CMD_READ, 4, 0, 1);

        // write starvation: 15 reads, then the write, then reads again
        do_reset();
        rd_req(1, 0, 5, 0);
        wr_req(1, 0, 5, 7);
        nrd = 0; nwr = 0; nread = 0;
        for (int c = 0; c <= 30; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            nrd += int'(bus.rd_ready);
            nwr += int'(bus.wr_ready);
            if (bus.issue_push && bus.issue_cmd == CMD_READ) nread++;
        end
        chk("B read grants before write", nrd, 15);
        chk("B write grants while starving", nwr, 0);
        chk("B READ pushes", nread, 15);
        @(negedge clk); #1;
        chk("B31 starved write wins", bus.wr_ready, 1);
        chk("B31 read loses", bus.rd_ready, 0);
        @(negedge clk); #1;
        chk_issue("B32 WRITE hit", 1, CMD_WRITE, 0, 0, 7);
        @(negedge clk); #1;
        chk("B33 reads resume", bus.rd_ready, 1);
        @(negedge clk); rd_req(0, 0, 0, 0); wr_req(0, 0, 0, 0);

        // refresh with banks 1 and 5 open
        do_reset();
        rd_req(1, 1, 'hA, 0);
        @(negedge clk); rd_req(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk); rd_req(1, 5, 'hB, 0); #1;
        chk("C3 grant bank 5", bus.rd_ready, 1);
        @(negedge clk); rd_req(0, 0, 0, 0);
        npush = 0;
        for (int c = 5; c <= 61; c++) begin
            @(negedge clk);
            if (c == 61) rd_req(1, 1, 'hA, 2);
            #1;
            if (c >= 6 && bus.issue_push) npush++;
        end
        chk("C quiet until refresh", npush, 0);
        chk("C61 refresh beats read", bus.rd_ready, 0);
        @(negedge clk); #1;
        chk_issue("C62 PRECHARGE bank 1", 1, CMD_PRECHARGE, 1, 0, 0);
        chk("C62 no ready during refresh", bus.rd_ready, 0);
        @(negedge clk); #1;
        chk_issue("C63 PRECHARGE bank 5", 1, CMD_PRECHARGE, 5, 0, 0);
        @(negedge clk); #1;
        chk_issue("C64 REFRESH", 1, CMD_REFRESH, 0, 0, 0);
        @(negedge clk); #1;
        chk("C65 pending cleared, read granted", bus.rd_ready, 1);
        @(negedge clk); rd_req(0, 0, 0, 0); #1;
        chk_issue("C66 bank 1 reopened", 1, CMD_ACTIVE, 1, 'hA, 0);
        @(negedge clk); #1;
        chk_issue("C67 READ", 1, CMD_READ, 1, 0, 2);

        // refresh stuck behind a full FIFO past a whole interval
        do_reset();
        bus.issue_full = 1'b1;
        novf = 0; ovf_cyc = -1;
        for (int c = 0; c <= 130; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (ref_overflow) begin
                novf++;
                ovf_cyc = c;
            end
        end
        chk("D overflow pulse count", novf, 1);
        chk("D overflow cycle", ovf_cyc, 122);
        chk_issue("D REFRESH held", 0, CMD_REFRESH, 0, 0, 0);
        @(negedge clk); bus.issue_full = 1'b0; #1;
        chk_issue("D REFRESH pushed", 1, CMD_REFRESH, 0, 0, 0);
        @(negedge clk); #1;
        chk_issue("D back to idle", 0, CMD_NOP, 0, 0, 0);

        // reset in the middle of a conflict sequence
        do_reset();
        rd_req(1, 3, 1, 0);
        @(negedge clk); rd_req(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk); rd_req(1, 3, 2, 0); #1;
        chk("E3 conflict grant", bus.rd_ready, 1);
        @(negedge clk); rd_req(0, 0, 0, 0); #1;
        chk_issue("E4 PRECHARGE", 1, CMD_PRECHARGE, 3, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        rd_req(1, 3, 2, 0);
        wr_req(1, 3, 2, 0);
        #1;
        chk_issue("E5 issue bus cleared by reset", 0, CMD_NOP, 0, 0, 0);
        chk("E5 rd_ready in reset", bus.rd_ready, 0);
        chk("E5 wr_ready in reset", bus.wr_ready, 0);
        do_reset();
        rd_req(1, 3, 2, 5);
        #1;
        chk("E grant after reset", bus.rd_ready, 1);
        @(negedge clk); rd_req(0, 0, 0, 0); #1;
        chk_issue("E ACTIVE without PRECHARGE", 1, CMD_ACTIVE, 3, 2, 0);
        @(negedge clk); #1;
        chk_issue("E READ", 1, CMD_READ, 3, 0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
